sprite_row_fetcher: RTL and testbench

- Read-side consumer of the dual-port sprite RAM's 16-bit VGA port (2048 words, 4 bpp, 4 pixels/word, 8 frames of 32x32).
- At each horizontal-blank start, fetches the one sprite row that intersects the upcoming scanline into a local 8-word line buffer.
- During active video, emits a palette index and an opacity flag per draw_x to the colour mapper.

---
 rtl/sprite_row_fetcher_if.sv | 28 ++
 rtl/sprite_row_fetcher.sv | 136 +++++++++++++
 tb/tb_sprite_row_fetcher.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_row_fetcher_if.sv
// Sprite RAM VGA-side port bundle.
// The fetcher is the master; the RAM model or wrapper is the slave.
interface sprite_row_fetcher_if;
  logic [10:0] ram_address;
  logic        ram_read;
  logic [15:0] ram_readdata;
  logic        ram_write;
  logic [1:0]  ram_byteenable;
  logic [15:0] ram_writedata;

  modport master (
    output ram_address,
    output ram_read,
    output ram_write,
    output ram_byteenable,
    output ram_writedata,
    input  ram_readdata
  );

  modport slave (
    input  ram_address,
    input  ram_read,
    input  ram_write,
    input  ram_byteenable,
    input  ram_writedata,
    output ram_readdata
  );
endinterface

// File: rtl/sprite_row_fetcher.sv
// Fetches one 32-pixel sprite row per hblank and decodes pixels by draw_x.
// Optional horizontal mirroring via macro SPRITE_HFLIP_EN.
module sprite_row_fetcher #(
  parameter int         SPRITE_W        = 32,
  parameter int         SPRITE_H        = 32,
  parameter logic [3:0] TRANSPARENT_IDX = 4'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        line_start,
  input  logic [9:0]  next_y,
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
  input  logic [2:0]  sprite_frame,
  input  logic        sprite_en,
  input  logic [9:0]  draw_x,
`ifdef SPRITE_HFLIP_EN
  input  logic        hflip,
`endif
  sprite_row_fetcher_if.master ram,
  output logic [3:0]  pixel_index,
  output logic        pixel_opaque,
  output logic        busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]  state;
  logic [2:0]  k;
  logic [2:0]  frame_q;
  logic [4:0]  row_q;
  logic [9:0]  sx_q;
  logic        row_hit;
  logic        cap_en;
  logic [2:0]  cap_k;
  logic [15:0] lbuf [8];
  logic        flip_q;

  logic [10:0] row_diff;
  logic        hit_next;
  logic        fetching;

  assign row_diff = {1'b0, next_y} - {1'b0, sprite_y};
  assign hit_next = sprite_en && (next_y >= sprite_y)
                    && (row_diff < 11'(SPRITE_H));

  assign fetching = (state == FETCH);
  assign busy     = (state != IDLE);

  assign ram.ram_read       = fetching;
  assign ram.ram_address    = fetching ? {frame_q, row_q, k} : 11'd0;
  assign ram.ram_write      = 1'b0;
  assign ram.ram_byteenable = 2'b00;
  assign ram.ram_writedata  = 16'h0000;

  // A line_start in any state restarts from the freshly latched sprite.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      k       <= 3'd0;
      frame_q <= 3'd0;
      row_q   <= 5'd0;
      sx_q    <= 10'd0;
      flip_q  <= 1'b0;
      row_hit <= 1'b0;
      cap_en  <= 1'b0;
      cap_k   <= 3'd0;
    end else begin
      cap_en <= fetching;
      cap_k  <= k;
      if (line_start) begin
        frame_q <= sprite_frame;
        row_q   <= row_diff[4:0];
        sx_q    <= sprite_x;
`ifdef SPRITE_HFLIP_EN
        flip_q  <= hflip;
`else
        flip_q  <= 1'b0;
`endif
        k       <= 3'd0;
        row_hit <= 1'b0;
        state   <= hit_next ? FETCH : IDLE;
      end else begin
        case (state)
          IDLE: ;
          FETCH: begin
            k <= k + 3'd1;
            if (k == 3'd7)
              state <= DRAIN;
          end
          DRAIN: begin
            row_hit <= 1'b1;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Read data lags the address by one cycle.
  always_ff @(posedge clk) begin
    if (cap_en)
      lbuf[cap_k] <= ram.ram_readdata;
  end

  logic [4:0]  col;
  logic [4:0]  cx;
  logic        in_range;
  logic [15:0] word_q;
  logic [3:0]  idx;
  logic        opaque_next;

  assign col      = draw_x[4:0] - sx_q[4:0];
  assign cx       = flip_q ? ~col : col;
  assign in_range = (draw_x >= sx_q)
                    && ({1'b0, draw_x} < ({1'b0, sx_q} + 11'(SPRITE_W)));
  assign word_q   = lbuf[cx[4:2]];
  assign idx      = word_q[{cx[1:0], 2'b00} +: 4];

  assign opaque_next = row_hit && !busy && in_range
                       && (idx != TRANSPARENT_IDX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pixel_index  <= 4'h0;
      pixel_opaque <= 1'b0;
    end else begin
      pixel_index  <= opaque_next ? idx : 4'h0;
      pixel_opaque <= opaque_next;
    end
  end

endmodule

// File: tb/tb_sprite_row_fetcher.sv
// Directed bench for sprite_row_fetcher with a 1-cycle-latency RAM model.
// Expected values are hand-derived from the sprite memory image below.
module tb_sprite_row_fetcher;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       line_start = 1'b0;
  logic [9:0] next_y = 10'd0;
  logic [9:0] sprite_x = 10'd50;
  logic [9:0] sprite_y = 10'd100;
  logic [2:0] sprite_frame = 3'd2;
  logic       sprite_en = 1'b1;
  logic [9:0] draw_x = 10'd0;
`ifdef SPRITE_HFLIP_EN
  logic       hflip = 1'b0;
`endif
  logic [3:0] pixel_index;
  logic       pixel_opaque;
  logic       busy;

  int checks = 0;
  int fails  = 0;

  logic [15:0] mem [2048];

  sprite_row_fetcher_if ram_if ();

  sprite_row_fetcher dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .line_start   (line_start),
    .next_y       (next_y),
    .sprite_x     (sprite_x),
    .sprite_y     (sprite_y),
    .sprite_frame (sprite_frame),
    .sprite_en    (sprite_en),
    .draw_x       (draw_x),
`ifdef SPRITE_HFLIP_EN
    .hflip        (hflip),
`endif
    .ram          (ram_if),
    .pixel_index  (pixel_index),
    .pixel_opaque (pixel_opaque),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (ram_if.ram_read)
      ram_if.ram_readdata <= mem[ram_if.ram_address];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_line(input logic [9:0] ny);
    next_y = ny;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    chk("wait_idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic px(input string tag, input logic [9:0] dx,
                    input logic [3:0] ei, input logic eo);
    draw_x = dx;
    tick();
    chk({tag, "_idx"}, {28'd0, pixel_index}, {28'd0, ei});
    chk({tag, "_op"}, {31'd0, pixel_opaque}, {31'd0, eo});
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2048; i++)
      mem[i] = 16'h7777;
    // frame 2, row 5 -> base 0x228
    mem[11'h228] = 16'h4321;
    mem[11'h229] = 16'h8765;
    mem[11'h22A] = 16'h0CBA;
    mem[11'h22D] = 16'hFEDC;
    mem[11'h22F] = 16'hA987;

    tick();
    tick();
    chk("rst_read", {31'd0, ram_if.ram_read}, 32'd0);
    chk("rst_addr", {21'd0, ram_if.ram_address}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_op", {31'd0, pixel_opaque}, 32'd0);
    chk("rst_idx", {28'd0, pixel_index}, 32'd0);
    chk("rst_wr", {31'd0, ram_if.ram_write}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Fetch addressing
    start_line(10'd105);
    for (int k = 0; k < 8; k++) begin
      chk("fetch_addr", {21'd0, ram_if.ram_address}, 32'h228 + k);
      chk("fetch_read", {31'd0, ram_if.ram_read}, 32'd1);
      chk("fetch_busy", {31'd0, busy}, 32'd1);
      tick();
    end
    chk("drain_busy", {31'd0, busy}, 32'd1);
    chk("drain_read", {31'd0, ram_if.ram_read}, 32'd0);
    tick();
    chk("done_busy", {31'd0, busy}, 32'd0);

    // Pixel decode
    px("px50", 10'd50, 4'h1, 1'b1);
    px("px51", 10'd51, 4'h2, 1'b1);
    px("px52", 10'd52, 4'h3, 1'b1);
    px("px53", 10'd53, 4'h4, 1'b1);
    px("px54", 10'd54, 4'h5, 1'b1);
    px("px49", 10'd49, 4'h0, 1'b0);
    px("px82", 10'd82, 4'h0, 1'b0);
    px("px81", 10'd81, 4'hA, 1'b1);
    px("px78", 10'd78, 4'h7, 1'b1);
    px("px60", 10'd60, 4'hC, 1'b1);
    px("px61_transp", 10'd61, 4'h0, 1'b0);
    px("px70", 10'd70, 4'hC, 1'b1);

    // Sprite inputs changed mid-line have no effect
    sprite_x = 10'd0;
    sprite_frame = 3'd0;
    px("tear50", 10'd50, 4'h1, 1'b1);
    sprite_x = 10'd50;
    sprite_frame = 3'd2;

    // Row misses
    start_line(10'd99);
    chk("miss99_busy", {31'd0, busy}, 32'd0);
    chk("miss99_read", {31'd0, ram_if.ram_read}, 32'd0);
    px("miss99_px", 10'd50, 4'h0, 1'b0);
    start_line(10'd132);
    chk("miss132_busy", {31'd0, busy}, 32'd0);
    chk("miss132_read", {31'd0, ram_if.ram_read}, 32'd0);
    px("miss132_px", 10'd50, 4'h0, 1'b0);
    sprite_en = 1'b0;
    start_line(10'd105);
    chk("dis_read", {31'd0, ram_if.ram_read}, 32'd0);
    sprite_en = 1'b1;

    // Last row of sprite is a hit
    start_line(10'd131);
    chk("row31_addr", {21'd0, ram_if.ram_address}, 32'h2F8);
    wait_idle();
    px("row31_px", 10'd50, 4'h7, 1'b1);

    // Abort: restart 4 cycles into a fetch
    start_line(10'd105);
    tick();
    tick();
    tick();
    tick();
    chk("abort_pre_addr", {21'd0, ram_if.ram_address}, 32'h22C);
    start_line(10'd106);
    chk("abort_addr0", {21'd0, ram_if.ram_address}, 32'h230);
    n = 0;
    while (busy && n < 20) begin
      chk("abort_op", {31'd0, pixel_opaque}, 32'd0);
      tick();
      n++;
    end
    chk("abort_busy_len", n, 32'd9);
    px("abort_px", 10'd50, 4'h7, 1'b1);

    // Asynchronous reset mid-fetch
    start_line(10'd105);
    tick();
    tick();
    chk("prerst_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_read", {31'd0, ram_if.ram_read}, 32'd0);
    chk("arst_addr", {21'd0, ram_if.ram_address}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_op", {31'd0, pixel_opaque}, 32'd0);
    reset_n = 1'b1;
    tick();
    chk("postrst_busy", {31'd0, busy}, 32'd0);
    px("postrst_px", 10'd50, 4'h0, 1'b0);
    start_line(10'd105);
    chk("restart_addr", {21'd0, ram_if.ram_address}, 32'h228);
    wait_idle();
    px("restart_px", 10'd51, 4'h2, 1'b1);

    // Right-edge clip
    sprite_x = 10'd1000;
    start_line(10'd105);
    wait_idle();
    px("clip1023", 10'd1023, 4'hF, 1'b1);
    px("clip1020", 10'd1020, 4'hC, 1'b1);
    px("clip1000", 10'd1000, 4'h1, 1'b1);
    px("clip999", 10'd999, 4'h0, 1'b0);
    px("clip0", 10'd0, 4'h0, 1'b0);
    px("clip7", 10'd7, 4'h0, 1'b0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
